// File: rtl/ld_rate_meter.sv
// Blink-rate recovery: measures rise-to-rise period of an LED line and reports
// a debounced mode code (0 = stopped, 1 = fastest .. 3 = slowest).
module ld_rate_meter #(
  parameter int PER_M1  = 64,
  parameter int PER_M2  = 128,
  parameter int PER_M3  = 320,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        SCLK,
  input  logic        RST_N,
  input  logic        LD_IN,
  output logic [1:0]  MODE,
  output logic        VALID,
  output logic [15:0] PERIOD,
  output logic        UPD,
  output logic        ERR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  // Acceptance windows, widened to 17 bits so neither bound can wrap.
  localparam logic [16:0] LO1 = 17'((PER_M1 > TOL) ? PER_M1 - TOL : 0);
  localparam logic [16:0] HI1 = 17'(PER_M1 + TOL);
  localparam logic [16:0] LO2 = 17'((PER_M2 > TOL) ? PER_M2 - TOL : 0);
  localparam logic [16:0] HI2 = 17'(PER_M2 + TOL);
  localparam logic [16:0] LO3 = 17'((PER_M3 > TOL) ? PER_M3 - TOL : 0);
  localparam logic [16:0] HI3 = 17'(PER_M3 + TOL);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  logic        s1, s2, s3;
  logic        rise;
  logic [15:0] cnt;
  logic [16:0] cnt_w;
  logic [1:0]  cls;
  logic        cls_ok;
  logic        timed_out;
  logic [1:0]  state;
  logic [1:0]  cand;

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= LD_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= 16'd1;
    end else if (cnt != '1) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    cnt_w = {1'b0, cnt};
    cls   = 2'd0;
    if ((cnt_w >= LO1) && (cnt_w <= HI1)) begin
      cls = 2'd1;
    end else if ((cnt_w >= LO2) && (cnt_w <= HI2)) begin
      cls = 2'd2;
    end else if ((cnt_w >= LO3) && (cnt_w <= HI3)) begin
      cls = 2'd3;
    end
    cls_ok    = (cls != 2'd0);
    timed_out = (cnt >= TO_LIM);
  end

  // rise takes priority over the timeout threshold in every state.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      cand   <= '0;
      MODE   <= '0;
      VALID  <= 1'b0;
      PERIOD <= '0;
      UPD    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      UPD <= 1'b0;
      ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_ARM;
          end else if (timed_out) begin
            MODE  <= '0;
            VALID <= 1'b1;
          end
        end
        ST_ARM: begin
          if (rise) begin
            state  <= ST_TRACK;
            PERIOD <= cnt;
            UPD    <= 1'b1;
            cand   <= cls;
            ERR    <= ~cls_ok;
          end else if (timed_out) begin
            state <= ST_IDLE;
            MODE  <= '0;
            VALID <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (rise) begin
            PERIOD <= cnt;
            UPD    <= 1'b1;
            if (cls_ok && (cls == cand)) begin
              MODE  <= cls;
              VALID <= 1'b1;
            end else begin
              VALID <= 1'b0;
              cand  <= cls;
              ERR   <= ~cls_ok;
            end
          end else if (timed_out) begin
            state <= ST_IDLE;
            MODE  <= '0;
            VALID <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ld_rate_meter.sv
// Bench for ld_rate_meter: table of periods with expected outcomes, corner
// sequences, and random periods, all checked cycle by cycle against a model.
module tb_ld_rate_meter;

  localparam int PM1 = 64;
  localparam int PM2 = 128;
  localparam int PM3 = 320;
  localparam int TOLV = 4;
  localparam int TMO = 1024;

  logic        SCLK = 1'b0;
  logic        RST_N;
  logic        LD_IN;
  logic [1:0]  MODE;
  logic        VALID;
  logic [15:0] PERIOD;
  logic        UPD;
  logic        ERR;

  ld_rate_meter #(
    .PER_M1(PM1), .PER_M2(PM2), .PER_M3(PM3), .TOL(TOLV), .TIMEOUT(TMO)
  ) dut (
    .SCLK(SCLK), .RST_N(RST_N), .LD_IN(LD_IN), .MODE(MODE), .VALID(VALID),
    .PERIOD(PERIOD), .UPD(UPD), .ERR(ERR)
  );

  always #5 SCLK = ~SCLK;

  int nvec = 0;
  int nmis = 0;
  int ncyc = 0;

  // Reference model state: rise times as cycle stamps, phase = rises seen since idle.
  logic [2:0]  hist;
  int          now_c, last_c, phase, m_cand;
  logic [1:0]  m_mode;
  logic        m_valid, m_upd, m_err;
  logic [15:0] m_per;

  logic seen_upd, seen_err, seen_mode0;
  int   last_upd;

  typedef struct {
    int per;
    int mode;
    int valid;
    int period;
    int upd;
    int err;
  } row_t;
  row_t tbl[16];

  function automatic int classify(input int d);
    int pers[3];
    pers = '{PM1, PM2, PM3};
    for (int unsigned k = 0; k < 3; k++) begin
      if (((d > pers[k]) ? d - pers[k] : pers[k] - d) <= TOLV) return int'(k) + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    hist = '0; now_c = 0; last_c = 1; phase = 0; m_cand = 0;
    m_mode = '0; m_valid = 1'b0; m_upd = 1'b0; m_err = 1'b0; m_per = '0;
  endtask

  task automatic model_step(input logic v);
    int d, c;
    logic r;
    if (!RST_N) begin
      model_reset();
      return;
    end
    r = hist[1] & ~hist[2];
    now_c++;
    d = now_c - last_c;
    if (d > 65535) d = 65535;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (r) begin
      c = classify(d);
      if (phase == 0) begin
        phase = 1;
      end else begin
        m_per = 16'(d);
        m_upd = 1'b1;
        if (phase == 1) begin
          phase  = 2;
          m_cand = c;
          m_err  = (c == 0);
        end else if (c != 0 && c == m_cand) begin
          m_mode  = 2'(c);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_cand  = c;
          m_err   = (c == 0);
        end
      end
      last_c = now_c;
    end else if (d >= TMO) begin
      phase   = 0;
      m_mode  = '0;
      m_valid = 1'b1;
    end
    hist = {hist[1], hist[0], v};
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v);
    LD_IN = v;
    @(posedge SCLK);
    model_step(v);
    #1;
    ncyc++;
    nvec++;
    if (MODE !== m_mode || VALID !== m_valid || PERIOD !== m_per || UPD !== m_upd || ERR !== m_err) begin
      nmis++;
      $display("FAIL model cyc=%0d: got mode=%0d valid=%0b period=%0d upd=%0b err=%0b expected mode=%0d valid=%0b period=%0d upd=%0b err=%0b",
               ncyc, MODE, VALID, PERIOD, UPD, ERR, m_mode, m_valid, m_per, m_upd, m_err);
    end
    if (UPD === 1'b1) begin
      seen_upd = 1'b1;
      last_upd = ncyc;
    end
    if (ERR === 1'b1) seen_err = 1'b1;
    if (MODE === 2'd0) seen_mode0 = 1'b1;
  endtask

  // One blink period starting with a rising transition.
  task automatic seg(input int len);
    for (int unsigned c = 0; c < len; c++) cyc(int'(c) < len / 2);
  endtask

  task automatic clr_seen();
    seen_upd = 1'b0; seen_err = 1'b0; seen_mode0 = 1'b0;
  endtask

  initial begin
    int len, first_stop, first_valid, sel;
    tbl[0]  = '{0,   0, 0, 0,   0, 0};
    tbl[1]  = '{64,  0, 0, 64,  1, 0};
    tbl[2]  = '{64,  1, 1, 64,  1, 0};
    tbl[3]  = '{128, 1, 0, 128, 1, 0};
    tbl[4]  = '{128, 2, 1, 128, 1, 0};
    tbl[5]  = '{320, 2, 0, 320, 1, 0};
    tbl[6]  = '{320, 3, 1, 320, 1, 0};
    tbl[7]  = '{64,  3, 0, 64,  1, 0};
    tbl[8]  = '{68,  1, 1, 68,  1, 0};
    tbl[9]  = '{69,  1, 0, 69,  1, 1};
    tbl[10] = '{60,  1, 0, 60,  1, 0};
    tbl[11] = '{60,  1, 1, 60,  1, 0};
    tbl[12] = '{59,  1, 0, 59,  1, 1};
    tbl[13] = '{124, 1, 0, 124, 1, 0};
    tbl[14] = '{132, 2, 1, 132, 1, 0};
    tbl[15] = '{133, 2, 0, 133, 1, 1};

    RST_N = 1'b0;
    LD_IN = 1'b0;
    model_reset();
    clr_seen();
    last_upd = 0;

    // Reset held while the line blinks at the mode-1 rate.
    for (int unsigned c = 0; c < 192; c++) begin
      cyc((c % 64) < 32);
      chk("reset_hold", {MODE, VALID, PERIOD, UPD, ERR}, '0);
    end
    RST_N = 1'b1;
    for (int unsigned c = 0; c < 20; c++) cyc(1'b0);

    // Each row begins with a rise that closes a period of length tbl[i].per.
    for (int unsigned i = 0; i < 16; i++) begin
      len = (i + 1 < 16) ? tbl[i + 1].per : 100;
      clr_seen();
      seg(len);
      chk($sformatf("row%0d_mode", i), MODE, tbl[i].mode);
      chk($sformatf("row%0d_valid", i), VALID, tbl[i].valid);
      chk($sformatf("row%0d_period", i), PERIOD, tbl[i].period);
      chk($sformatf("row%0d_upd", i), seen_upd, tbl[i].upd);
      chk($sformatf("row%0d_err", i), seen_err, tbl[i].err);
    end

    // Stop: lock to mode 1, then hold the line low.
    seg(64); seg(64); seg(64);
    first_stop = -1;
    for (int unsigned c = 0; c < 1100; c++) begin
      cyc(c < 32);
      if (first_stop < 0 && VALID === 1'b1 && MODE === 2'd0) first_stop = ncyc;
    end
    chk("stop_delay", first_stop - last_upd, TMO);
    chk("stop_mode", MODE, 0);
    chk("stop_valid", VALID, 1);
    clr_seen();
    seg(64);
    chk("restart_first_upd", seen_upd, 0);
    clr_seen();
    seg(64);
    chk("restart_second_upd", seen_upd, 1);
    chk("restart_period", PERIOD, 64);
    seg(64);
    chk("relock_mode", MODE, 1);
    chk("relock_valid", VALID, 1);

    // Rise lands on the cycle the counter reaches the timeout threshold.
    clr_seen();
    seg(1024);
    clr_seen();
    for (int unsigned c = 0; c < 8; c++) cyc(1'b1);
    chk("thr_period", PERIOD, TMO);
    chk("thr_err", seen_err, 1);
    chk("thr_no_timeout", seen_mode0, 0);
    chk("thr_valid", VALID, 0);
    chk("thr_mode_held", MODE, 1);
    for (int unsigned c = 0; c < 8; c++) cyc(1'b0);

    // Asynchronous reset in mid-TRACK, observed before the next clock edge.
    RST_N = 1'b0;
    #1;
    chk("async_rst_mode", MODE, 0);
    chk("async_rst_valid", VALID, 0);
    chk("async_rst_period", PERIOD, 0);
    chk("async_rst_upd", UPD, 0);
    chk("async_rst_err", ERR, 0);
    model_reset();
    for (int unsigned c = 0; c < 3; c++) cyc(1'b0);
    RST_N = 1'b1;

    // Line that never toggles after reset.
    first_valid = -1;
    for (int unsigned c = 1; c <= 1100; c++) begin
      cyc(1'b0);
      if (first_valid < 0 && VALID === 1'b1) first_valid = int'(c);
    end
    chk("idle_timeout_cycle", first_valid, TMO + 1);
    chk("idle_timeout_mode", MODE, 0);

    // Random periods, near-nominal and arbitrary, against the model.
    for (int unsigned i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: len = PM1 + int'($urandom_range(0, 12)) - 6;
        1: len = PM2 + int'($urandom_range(0, 12)) - 6;
        2: len = PM3 + int'($urandom_range(0, 12)) - 6;
        default: len = int'($urandom_range(2, 400));
      endcase
      seg(len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ld_rate_meter.md
# ld_rate_meter

Reads back the blink output driven by the LED `controller` and recovers which rate the controller was set to. It measures the period between rising edges of one LED line in `SCLK` cycles, classifies that period against three nominal rates, and reports a debounced mode code on the same 2-bit encoding as `SW`: 0 means stopped, 1 is the fastest rate, 3 is the slowest. It sits beside the controller for self-check and for the on-board loopback display.

## Interface
- `PER_M1`, default 64: nominal period of mode 1, in `SCLK` cycles.
- `PER_M2`, default 128: nominal period of mode 2, in `SCLK` cycles.
- `PER_M3`, default 320: nominal period of mode 3, in `SCLK` cycles.
- `TOL`, default 4: accepted ± deviation from a nominal period, in cycles, inclusive.
- `TIMEOUT`, default 1024: number of cycles without a rising edge that declares the line stopped. Legal range is 2..65534.
- `SCLK`, in, 1: the single clock; all logic is on its rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `LD_IN`, in, 1: the monitored LED line; asynchronous to `SCLK`.
- `MODE`, out, 2: confirmed mode code.
- `VALID`, out, 1: high while `MODE` is confirmed.
- `PERIOD`, out, 16: last measured rise-to-rise period, in cycles.
- `UPD`, out, 1: one-cycle pulse when `PERIOD` is updated.
- `ERR`, out, 1: one-cycle pulse when a measured period matches no mode.

## Operation
- **Synchronizer and edge detect:** `LD_IN` passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3. `rise = s2 & ~s3`.
- **Counter:** `cnt` is 16 bits.
  - On `rise`: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at 16'hFFFF.
  - The value of `cnt` in a `rise` cycle equals the number of cycles since the previous rise.
- **Classification** (combinational on `cnt`):
  - class = k if |cnt − PER_Mk| ≤ TOL, for k = 1, 2, 3. On overlap the lowest k wins.
  - Otherwise the period is invalid.
  - Compare with widened or unsigned-safe arithmetic; never use wrapped subtraction.
- **State machine** with states IDLE, ARM, TRACK; `cand` is a 2-bit register.
  - **IDLE:** on `rise` go to ARM. No `PERIOD` update, because the first edge has no reference.
  - **ARM:** on `rise`:
    - go to TRACK, `PERIOD <= cnt`, `UPD` = 1.
    - `cand <=` class, or 0 if invalid.
    - `ERR` = 1 if invalid.
    - `VALID` and `MODE` are unchanged.
  - **TRACK:** on `rise`:
    - `PERIOD <= cnt`, `UPD` = 1.
    - If the class is valid and equal to `cand`: `MODE <=` class, `VALID <= 1`.
    - Otherwise: `VALID <= 0`, `cand <=` class (0 if invalid), `MODE` held. `ERR` = 1 if invalid.
  - **Timeout:** in ARM or TRACK, with no `rise` and `cnt ≥ TIMEOUT`:
    - go to IDLE, `MODE <= 0`, `VALID <= 1`.
    - Stopped is a confirmed result.
  - **Timeout while in IDLE:** if `cnt ≥ TIMEOUT`, force `MODE <= 0`, `VALID <= 1`. This covers a line that never toggles after reset.
- **Simultaneous rise and timeout threshold:** `rise` wins. The period is measured and classified; no timeout action is taken.
- **Reset values** (asynchronous on `RST_N` low; every flop clears immediately, mid-operation included):
  - state = IDLE
  - `cnt`, `cand`, s1, s2, s3 = 0
  - `MODE` = 0, `VALID` = 0, `PERIOD` = 0, `UPD` = 0, `ERR` = 0

## Timing
- From an `LD_IN` rising transition to the `rise` cycle: 2–3 `SCLK` cycles (synchronizer). Period measurement has no bias, since every edge sees the same latency.
- `PERIOD`, `UPD`, `ERR`, `MODE` and `VALID` are registered. They change on the clock edge that ends the `rise` cycle.
- After reset, the earliest `VALID` = 1 with a nonzero `MODE` is on the third rising edge: IDLE→ARM, ARM→TRACK, then confirmation.
- A mode change needs two consecutive matching periods. `VALID` drops on the first mismatching period.
- Timeout fires on the cycle where `cnt` reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after the last `rise`.
- `UPD` and `ERR` are never high for more than one consecutive cycle.

## Test plan
- **Reset hold:** hold `RST_N` = 0 with `LD_IN` toggling at period 64 → `MODE` = 0, `VALID` = 0, `PERIOD` = 0, `UPD` = 0 and `ERR` = 0 throughout. Assert `RST_N` low in mid-TRACK → all outputs read 0 before the next `SCLK` edge.
- **Lock to mode 1:** square wave of period 64 → `UPD` pulses from the 2nd rise onward with `PERIOD` = 64. On the 3rd rise, `MODE` = 1 and `VALID` = 1.
- **Change to mode 2:** switch to period 128 → 1st new period gives `VALID` = 0, `MODE` = 1, `PERIOD` = 128. 2nd new period gives `MODE` = 2, `VALID` = 1. Repeat with period 320 → `MODE` = 3.
- **Tolerance edges:**
  - period 68 → accepted as mode 1.
  - period 69 → `ERR` pulse, `VALID` = 0, `MODE` held.
  - period 60 → accepted as mode 1.
- **Stop:** hold `LD_IN` low after lock → exactly 1024 cycles after the last `rise`, `MODE` = 0, `VALID` = 1, state IDLE. The next rise produces no `UPD`; the following rise produces `UPD`.
- **Rise at threshold:** a rise arrives exactly when `cnt` = `TIMEOUT` → treated as a period measurement (`PERIOD` = 1024, `ERR` pulse), no timeout. A line that never toggles after reset → `MODE` = 0, `VALID` = 1 after 1024 cycles.
